// File: rtl/zrle_comp.sv
// Zero-run-length / lane-sparsity encoder: each 64-bit word becomes a prefix code
// selected by its zero 16-bit lanes, packed MSB-first into framed 64-bit output words.
module zrle_comp #(
  parameter int IN_BURST = 16,
  parameter int MAX_OUT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [63:0] data_i,
  input  logic        sop_i,
  input  logic        eop_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [63:0] data_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic        ovf_o,
  input  logic        ready_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]   state;
  logic [127:0] acc;
  logic [7:0]   fill;
  logic [3:0]   in_cnt;
  logic [4:0]   out_cnt;
  logic         first_pend;

  logic [15:0]  l0, l1, l2, l3;
  logic [3:0]   nz;
  logic [65:0]  code_r, code_la;
  logic [6:0]   code_len;
  logic         load, accept, start, append, last_word;
  logic [7:0]   fill_rem, base_fill, fill_nxt;
  logic [127:0] acc_rem, base_acc, placed, acc_nxt;
  logic [4:0]   out_nxt;
  logic         eop_unused;

  assign eop_unused = eop_i;

  assign l0 = data_i[15:0];
  assign l1 = data_i[31:16];
  assign l2 = data_i[47:32];
  assign l3 = data_i[63:48];
  assign nz = {|l3, |l2, |l1, |l0};

  always_comb begin
    code_r   = '0;
    code_len = 7'd6;
    case (nz)
      4'b0000: begin code_r = '0;                              code_len = 7'd6;  end
      4'b0001: begin code_r = 66'({6'b000001, l0});            code_len = 7'd22; end
      4'b0010: begin code_r = 66'({5'b00001, l1});             code_len = 7'd21; end
      4'b0100: begin code_r = 66'({5'b00010, l2});             code_len = 7'd21; end
      4'b1000: begin code_r = 66'({5'b00011, l3});             code_len = 7'd21; end
      4'b0011: begin code_r = 66'({4'b0010, l1, l0});          code_len = 7'd36; end
      4'b0101: begin code_r = 66'({4'b0011, l2, l0});          code_len = 7'd36; end
      4'b1001: begin code_r = 66'({4'b0100, l3, l0});          code_len = 7'd36; end
      4'b0110: begin code_r = 66'({4'b0101, l2, l1});          code_len = 7'd36; end
      4'b1010: begin code_r = 66'({4'b0110, l3, l1});          code_len = 7'd36; end
      4'b1100: begin code_r = 66'({4'b0111, l3, l2});          code_len = 7'd36; end
      4'b0111: begin code_r = 66'({4'b1000, l2, l1, l0});      code_len = 7'd52; end
      4'b1011: begin code_r = 66'({4'b1001, l3, l1, l0});      code_len = 7'd52; end
      4'b1101: begin code_r = 66'({4'b1010, l3, l2, l0});      code_len = 7'd52; end
      4'b1110: begin code_r = 66'({4'b1011, l3, l2, l1});      code_len = 7'd52; end
      default: begin code_r = {2'b11, data_i};                 code_len = 7'd66; end
    endcase
  end

  // Code is left-aligned, then dropped in just below the current fill point.
  assign code_la = code_r << (7'd66 - code_len);

  assign load = (!valid_o || ready_i) &&
                ((fill >= 8'd64) || (state == FLUSH && fill != 8'd0));
  assign last_word = (state == FLUSH) && (fill <= 8'd64);

  assign fill_rem = load ? ((fill >= 8'd64) ? fill - 8'd64 : 8'd0) : fill;
  assign acc_rem  = load ? (acc << 64) : acc;

  assign ready_o = (state != FLUSH) && (fill_rem <= 8'd62);
  assign accept  = valid_i && ready_o;
  assign start   = accept && (state == IDLE) && sop_i;
  assign append  = start || (accept && state == RUN);

  // A new burst starts from an empty accumulator with the 2-bit zero header.
  assign base_fill = (state == IDLE) ? 8'd2 : fill_rem;
  assign base_acc  = (state == IDLE) ? '0 : acc_rem;
  assign placed    = {code_la, 62'b0} >> base_fill;

  assign acc_nxt  = append ? (base_acc | placed) : acc_rem;
  assign fill_nxt = append ? (base_fill + {1'b0, code_len}) : fill_rem;
  assign out_nxt  = first_pend ? 5'd1 : out_cnt + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      fill       <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      first_pend <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      fill <= fill_nxt;

      case (state)
        IDLE: begin
          if (start) begin
            in_cnt <= 4'd1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + 4'd1;
            if (in_cnt == 4'(IN_BURST - 1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (load && last_word) begin
            in_cnt <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        valid_o    <= 1'b1;
        data_o     <= acc[127:64];
        sop_o      <= first_pend;
        eop_o      <= last_word;
        out_cnt    <= out_nxt;
        ovf_o      <= last_word && (int'(out_nxt) > MAX_OUT);
        first_pend <= 1'b0;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end

      if (start) first_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zrle_comp.sv
// Self-checking bench for zrle_comp: a bit-queue reference encoder and a
// bit-serial decoder are compared against the DUT's framed output stream.
module tb_zrle_comp;
  localparam int MAX_OUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        sop_i = 1'b0;
  logic        eop_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        ready_o, valid_o, sop_o, eop_o, ovf_o;
  logic [63:0] data_o;

  zrle_comp #(.IN_BURST(16), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .sop_i(sop_i), .eop_i(eop_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o), .ovf_o(ovf_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [63:0] got_d[$];
  bit          got_s[$], got_e[$], got_o[$];
  logic [63:0] exp_d[$];
  bit          exp_s[$], exp_e[$], exp_o[$];
  bit          bq[$];
  logic [63:0] cur_w[16];
  logic [63:0] dec_w[16];
  int          rp;
  int          stall_cnt;
  bit          done;
  bit          rdy_after_last;

  always @(negedge clk)
    if (rst_n && valid_o && ready_i) begin
      got_d.push_back(data_o);
      got_s.push_back(sop_o);
      got_e.push_back(eop_o);
      got_o.push_back(ovf_o);
    end

  // ---------------- reference encoder ----------------
  function automatic void push_bits(logic [63:0] v, int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endfunction

  function automatic void push_code(logic [63:0] d);
    int nzl[$];
    logic [15:0] ln[4];
    int sum = 0;
    for (int k = 3; k >= 0; k--) begin
      ln[k] = d[16*k +: 16];
      if (ln[k] != 16'h0) begin nzl.push_back(k); sum += k; end
    end
    case (nzl.size())
      0: push_bits(64'd0, 6);
      1: if (nzl[0] == 0) push_bits(64'd1, 6); else push_bits(64'(nzl[0]), 5);
      2: begin
        int base;
        base = (nzl[1] == 0) ? 0 : (nzl[1] == 1) ? 3 : 5;
        push_bits(64'(2 + base + nzl[0] - nzl[1] - 1), 4);
      end
      3: push_bits(64'(8 + 3 - (6 - sum)), 4);
      default: push_bits(64'd3, 2);
    endcase
    foreach (nzl[i]) push_bits(64'(ln[nzl[i]]), 16);
  endfunction

  function automatic void build_expected();
    int n;
    logic [63:0] wv;
    bq.delete(); exp_d.delete(); exp_s.delete(); exp_e.delete(); exp_o.delete();
    push_bits(64'd0, 2);
    for (int i = 0; i < 16; i++) push_code(cur_w[i]);
    while (bq.size() % 64 != 0) bq.push_back(1'b0);
    n = bq.size() / 64;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 64; b++) wv[63-b] = bq[i*64+b];
      exp_d.push_back(wv);
      exp_s.push_back(i == 0);
      exp_e.push_back(i == n - 1);
      exp_o.push_back((i == n - 1) && (n > MAX_OUT));
    end
  endfunction

  // ---------------- reference decoder ----------------
  function automatic logic [63:0] rd(int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) begin
      v = v << 1;
      if (rp / 64 < got_d.size()) v[0] = got_d[rp/64][63 - rp % 64];
      rp++;
    end
    return v;
  endfunction

  function automatic void decode();
    rp = 2;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] ln[4];
      int hi = -1, lo = -1, zl = -1, one = -1, p, v;
      for (int k = 0; k < 4; k++) ln[k] = '0;
      p = int'(rd(2));
      if (p == 3) begin
        dec_w[i] = rd(64);
        continue;
      end
      v = int'(rd(2));
      if (p == 2) zl = 3 - v;
      else if (p == 1) begin
        case (v)
          0: begin hi = 3; lo = 0; end
          1: begin hi = 2; lo = 1; end
          2: begin hi = 3; lo = 1; end
          default: begin hi = 3; lo = 2; end
        endcase
      end else begin
        if (v == 2) begin hi = 1; lo = 0; end
        else if (v == 3) begin hi = 2; lo = 0; end
        else if (v == 1) one = (rd(1) != 0) ? 3 : 2;
        else if (rd(1) != 0) one = 1;
        else if (rd(1) != 0) one = 0;
      end
      if (zl >= 0) for (int k = 3; k >= 0; k--) begin if (k != zl) ln[k] = 16'(rd(16)); end
      if (hi >= 0) begin ln[hi] = 16'(rd(16)); ln[lo] = 16'(rd(16)); end
      if (one >= 0) ln[one] = 16'(rd(16));
      dec_w[i] = {ln[3], ln[2], ln[1], ln[0]};
    end
  endfunction

  // ---------------- stimulus ----------------
  function automatic logic [63:0] sparse_word();
    logic [63:0] w;
    for (int k = 0; k < 4; k++)
      w[16*k +: 16] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
    return w;
  endfunction

  function automatic logic [63:0] dense_word();
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[16*k +: 16] = 16'($urandom_range(1, 65535));
    return w;
  endfunction

  task automatic drive_word(input logic [63:0] d, input bit s, input bit e);
    bit ok = 0;
    valid_i = 1'b1; data_i = d; sop_i = s; eop_i = e;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); ok = ready_o;
      @(posedge clk); #1;
      if (ok) break;
      stall_cnt++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: word %h not accepted, required acceptance within 400 cycles", d);
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic drive_burst();
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) drive_word(cur_w[i], i == 0, i == 15);
    @(negedge clk); rdy_after_last = ready_o;
  endtask

  task automatic wait_eop();
    bit ok = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(posedge clk);
      if (got_e.size() > 0 && got_e[got_e.size()-1]) ok = 1;
    end
    #1;
    if (!ok) begin
      total++; bad++;
      $display("FAIL eop_timeout: got %0d words without eop, required eop within 3000 cycles", got_d.size());
    end
  endtask

  task automatic run_burst(input int rmode);
    got_d.delete(); got_s.delete(); got_e.delete(); got_o.delete();
    build_expected();
    done = 0;
    fork
      begin drive_burst(); wait_eop(); done = 1; end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (rmode != 0 && !done) ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({valid_o, sop_o, eop_o, ovf_o, data_o} !== 68'h0) begin
      bad++; $display("FAIL reset_outputs: got %h, required 0", {valid_o, sop_o, eop_o, ovf_o, data_o});
    end
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", ready_o); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ready_o, valid_o} !== 2'b10) begin
      bad++; $display("FAIL post_reset: ready/valid got %b, required 10", {ready_o, valid_o});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < 16; i++) cur_w[i] = '0;
    run_burst(0);
    total++;
    if (stall_cnt != 0) begin bad++; $display("FAIL zero_stalls: got %0d, required 0", stall_cnt); end
    total++;
    if (got_d.size() != 2) begin bad++; $display("FAIL zero_count: got %0d words, required 2", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_d[i], got_s[i], got_e[i], got_o[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_o[i]}) begin
        bad++; $display("FAIL zero_word%0d: got %h/%b%b%b required %h/%b%b%b", i, got_d[i], got_s[i], got_e[i],
                        got_o[i], exp_d[i], exp_s[i], exp_e[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_single_lane();
    for (int i = 0; i < 16; i++) cur_w[i] = '0;
    cur_w[0] = 64'h0000_0000_0000_ABCD;
    run_burst(0);
    total++;
    if (got_d.size() != 2 || got_d[0] !== 64'h01AB_CD00_0000_0000 || got_d[1] !== 64'h0 || got_e[1] !== 1'b1) begin
      bad++; $display("FAIL single_lane: got %0d words first %h, required 2 words 01abcd0000000000 then 0 with eop",
                      got_d.size(), (got_d.size() > 0) ? got_d[0] : 64'h0);
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_d[i], got_s[i], got_e[i], got_o[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_o[i]}) begin
        bad++; $display("FAIL single_word%0d: got %h/%b%b%b required %h/%b%b%b", i, got_d[i], got_s[i], got_e[i],
                        got_o[i], exp_d[i], exp_s[i], exp_e[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 16; i++) cur_w[i] = '1;
    run_burst(0);
    total++;
    if (got_d.size() != 17) begin bad++; $display("FAIL ones_count: got %0d words, required 17", got_d.size()); end
    else begin
      total++;
      if (got_d[0] !== 64'h3FFF_FFFF_FFFF_FFFF || got_d[16] !== 64'hFFFF_FFFF_C000_0000 || got_o[16] !== 1'b1) begin
        bad++; $display("FAIL ones_ends: got %h %h ovf %b, required 3fffffffffffffff ffffffffc0000000 ovf 1",
                        got_d[0], got_d[16], got_o[16]);
      end
    end
    total++;
    if (rdy_after_last !== 1'b0) begin bad++; $display("FAIL ones_flush_ready: got %b, required 0", rdy_after_last); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_d[i], got_s[i], got_e[i], got_o[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_o[i]}) begin
        bad++; $display("FAIL ones_word%0d: got %h/%b%b%b required %h/%b%b%b", i, got_d[i], got_s[i], got_e[i],
                        got_o[i], exp_d[i], exp_s[i], exp_e[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_lane_codes();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) cur_w[i] = sparse_word();
      cur_w[0] = (b == 0) ? 64'h1234_0000_5678_0000 : 64'h1111_0000_2222_3333;
      run_burst(1);
      total++;
      if (got_d.size() == 0) begin bad++; $display("FAIL lane_prefix%0d: got no words, required output", b); end
      else if (b == 0 && got_d[0][61:26] !== {4'b0110, 16'h1234, 16'h5678}) begin
        bad++; $display("FAIL lane_prefix0: got %h, required %h", got_d[0][61:26], {4'b0110, 16'h1234, 16'h5678});
      end else if (b == 1 && got_d[0][61:58] !== 4'b1001) begin
        bad++; $display("FAIL lane_prefix1: got %b, required 1001", got_d[0][61:58]);
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        total++;
        if ({got_d[i], got_s[i], got_e[i], got_o[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_o[i]}) begin
          bad++; $display("FAIL lane_word%0d_%0d: got %h/%b%b%b required %h/%b%b%b", b, i, got_d[i], got_s[i],
                          got_e[i], got_o[i], exp_d[i], exp_s[i], exp_e[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) cur_w[i] = (b % 3 == 2) ? dense_word() : sparse_word();
      run_burst(1);
      total++;
      if (got_d.size() != exp_d.size()) begin
        bad++; $display("FAIL rand_count%0d: got %0d words, required %0d", b, got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        total++;
        if ({got_d[i], got_s[i], got_e[i], got_o[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_o[i]}) begin
          bad++; $display("FAIL rand_word%0d_%0d: got %h/%b%b%b required %h/%b%b%b", b, i, got_d[i], got_s[i],
                          got_e[i], got_o[i], exp_d[i], exp_s[i], exp_e[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [66:0] snap;
    bit seen_low = 0;
    for (int i = 0; i < 16; i++) cur_w[i] = dense_word();
    got_d.delete(); got_s.delete(); got_e.delete(); got_o.delete();
    build_expected();
    fork
      begin drive_burst(); wait_eop(); end
      begin
        repeat (6) @(posedge clk);
        #1 ready_i = 1'b0;
        @(negedge clk);
        snap = {valid_o, sop_o, eop_o, data_o};
        total++;
        if (valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b, required 1", valid_o); end
        for (int c = 0; c < 9; c++) begin
          @(negedge clk);
          if (!ready_o) seen_low = 1;
          total++;
          if ({valid_o, sop_o, eop_o, data_o} !== snap) begin
            bad++; $display("FAIL bp_hold%0d: got %h, required %h", c, {valid_o, sop_o, eop_o, data_o}, snap);
          end
        end
        @(posedge clk); #1 ready_i = 1'b1;
      end
    join
    total++;
    if (!seen_low) begin bad++; $display("FAIL bp_ready_low: got ready_o always 1, required a low cycle"); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_d[i], got_s[i], got_e[i], got_o[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_o[i]}) begin
        bad++; $display("FAIL bp_word%0d: got %h/%b%b%b required %h/%b%b%b", i, got_d[i], got_s[i], got_e[i],
                        got_o[i], exp_d[i], exp_s[i], exp_e[i], exp_o[i]);
      end
    end
    decode();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (dec_w[i] !== cur_w[i]) begin bad++; $display("FAIL bp_loopback%0d: got %h, required %h", i, dec_w[i], cur_w[i]); end
    end
  endtask

  task automatic test_framing();
    got_d.delete(); got_s.delete(); got_e.delete(); got_o.delete();
    for (int i = 0; i < 3; i++) drive_word(dense_word(), 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (got_d.size() != 0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL nosop_drop: got %0d words valid %b, required 0 words valid 0", got_d.size(), valid_o);
    end
    for (int i = 0; i < 5; i++) drive_word(dense_word(), i == 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({valid_o, sop_o, eop_o, ovf_o, data_o, ready_o} !== {68'h0, 1'b1}) begin
      bad++; $display("FAIL midburst_reset: got %h, required %h", {valid_o, sop_o, eop_o, ovf_o, data_o, ready_o},
                      {68'h0, 1'b1});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) cur_w[i] = sparse_word();
    run_burst(0);
    total++;
    if (got_d.size() != exp_d.size()) begin
      bad++; $display("FAIL after_reset_count: got %0d words, required %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_d[i], got_s[i], got_e[i], got_o[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_o[i]}) begin
        bad++; $display("FAIL after_reset_word%0d: got %h/%b%b%b required %h/%b%b%b", i, got_d[i], got_s[i],
                        got_e[i], got_o[i], exp_d[i], exp_s[i], exp_e[i], exp_o[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_lane();
    test_all_ones();
    test_lane_codes();
    test_random();
    test_backpressure();
    test_framing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
